// File: rtl/aud_pkg.sv
// ---------------------------------------------------------------------------
// aud_pkg -- shared definitions for the audio level meter.
//   meter_state_t : peak-marker FSM states
//   NUM_SEG       : number of LED segments on the bar (also max level)
//   LEVEL_W       : width of level / peak values
//   CLIP_THRESH   : absolute sample magnitude that counts as clipping
//   sat_abs()     : saturating absolute value of a signed 16-bit sample
// ---------------------------------------------------------------------------
package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DECAY = 2'd2
  } meter_state_t;

  localparam int          NUM_SEG     = 25;
  localparam int          LEVEL_W     = 5;
  localparam logic [15:0] CLIP_THRESH = 16'd32000;

  // -32768 has no positive 16-bit counterpart, so it saturates to 32767.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] s);
    logic [15:0] r;
    if (s == 16'sh8000)
      r = 16'h7FFF;
    else if (s < 0)
      r = 16'(-s);
    else
      r = 16'(s);
    return r;
  endfunction

endpackage

// File: rtl/aud_therm_dec.sv
// ---------------------------------------------------------------------------
// aud_therm_dec -- purely combinational thermometer decoder.
//   value : input, 5-bit count 0..NUM_SEG
//   therm : output, NUM_SEG bits, therm[k] = 1 for every k < value
// ---------------------------------------------------------------------------
module aud_therm_dec
  import aud_pkg::*;
(
  input  logic [LEVEL_W-1:0] value,
  output logic [NUM_SEG-1:0] therm
);

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      assign therm[gi] = (value > LEVEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/aud_level_meter.sv
// ---------------------------------------------------------------------------
// aud_level_meter -- VU-style level meter with held/decaying peak marker.
//   i_AUD_BCLK : clock, everything on its rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_en       : meter enable (play or record active)
//   i_lrc      : LR clock, rising edge marks a completed sample
//   i_data     : signed 16-bit sample, stable while i_lrc is high
//   i_clear    : single-cycle clear of peak and clip latch
//   o_level    : current level 0..25 (|sample| >> 10, clamped)
//   o_peak     : held peak 0..25
//   o_bar      : LED bar, thermometer of o_level OR one-hot peak dot
//   o_clip     : latched clip indicator
// Optional feature: define AUD_LEVEL_METER_CLIP_EN to build the clip latch;
// otherwise o_clip is tied low.
// Timing: event cycle -> |sample| registered -> level/peak/bar visible two
// cycles after the event cycle. Hold/decay counters count sample events only.
// ---------------------------------------------------------------------------
module aud_level_meter
  import aud_pkg::*;
#(
  parameter int HOLD_SAMPLES  = 4800,
  parameter int DECAY_SAMPLES = 1600
) (
  input  logic               i_AUD_BCLK,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_lrc,
  input  logic [15:0]        i_data,
  input  logic               i_clear,
  output logic [LEVEL_W-1:0] o_level,
  output logic [LEVEL_W-1:0] o_peak,
  output logic [NUM_SEG-1:0] o_bar,
  output logic               o_clip
);

  localparam logic [15:0]        HOLD_LOAD  = 16'(HOLD_SAMPLES);
  localparam logic [15:0]        DECAY_LOAD = 16'(DECAY_SAMPLES);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL  = LEVEL_W'(NUM_SEG);

  logic               lrc_q;
  logic               evt;
  logic               evt_d1_reg;
  logic [15:0]        abs_reg;
  logic [LEVEL_W-1:0] level_now;
  logic [LEVEL_W-1:0] peak_dec;
  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] peak_reg;
  logic [15:0]        hold_cnt_reg;
  logic [15:0]        decay_cnt_reg;
  meter_state_t       state_reg;
  logic [NUM_SEG-1:0] level_therm;
  logic [NUM_SEG-1:0] peak_dot;

  assign evt = i_en & i_lrc & ~lrc_q;

  // Level from the registered magnitude; bits above 25 clamp to full scale.
  assign level_now = (abs_reg[15:10] > 6'(MAX_LEVEL)) ? MAX_LEVEL
                                                      : abs_reg[14:10];
  assign peak_dec  = peak_reg - LEVEL_W'(1);

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q         <= 1'b0;
      evt_d1_reg    <= 1'b0;
      abs_reg       <= '0;
      level_reg     <= '0;
      peak_reg      <= '0;
      hold_cnt_reg  <= '0;
      decay_cnt_reg <= '0;
      state_reg     <= S_IDLE;
    end else begin
      lrc_q <= i_lrc;
      if (!i_en) begin
        // Meter off: drop any in-flight sample and blank the display.
        evt_d1_reg <= 1'b0;
        level_reg  <= '0;
        peak_reg   <= '0;
        state_reg  <= S_IDLE;
      end else if (i_clear) begin
        // Clear wins over a coincident or in-flight sample; level is kept.
        evt_d1_reg <= 1'b0;
        peak_reg   <= '0;
        state_reg  <= S_IDLE;
      end else begin
        evt_d1_reg <= evt;
        if (evt)
          abs_reg <= sat_abs(i_data);
        if (evt_d1_reg) begin
          level_reg <= level_now;
          if ((level_now >= peak_reg) && (level_now != '0)) begin
            peak_reg     <= level_now;
            hold_cnt_reg <= HOLD_LOAD;
            state_reg    <= S_HOLD;
          end else begin
            case (state_reg)
              S_HOLD: begin
                if (hold_cnt_reg <= 16'd1) begin
                  hold_cnt_reg  <= '0;
                  decay_cnt_reg <= DECAY_LOAD;
                  state_reg     <= S_DECAY;
                end else begin
                  hold_cnt_reg <= hold_cnt_reg - 16'd1;
                end
              end
              S_DECAY: begin
                if (decay_cnt_reg <= 16'd1) begin
                  decay_cnt_reg <= DECAY_LOAD;
                  // Here level < peak, so peak-1 never drops below level
                  // unless they meet; the marker stops at the live level.
                  peak_reg <= (peak_dec > level_now) ? peak_dec : level_now;
                  if (peak_reg == LEVEL_W'(1))
                    state_reg <= S_IDLE;
                end else begin
                  decay_cnt_reg <= decay_cnt_reg - 16'd1;
                end
              end
              default: state_reg <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

`ifdef AUD_LEVEL_METER_CLIP_EN
  logic clip_reg;

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n)
      clip_reg <= 1'b0;
    else if (i_clear)
      clip_reg <= 1'b0;
    else if (i_en && evt_d1_reg && (abs_reg >= CLIP_THRESH))
      clip_reg <= 1'b1;
  end

  assign o_clip = clip_reg;
`else
  logic unused_abs_low;
  assign unused_abs_low = &{1'b0, abs_reg[9:0]};
  assign o_clip = 1'b0;
`endif

  aud_therm_dec u_level_therm (
    .value (level_reg),
    .therm (level_therm)
  );

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_dot
      assign peak_dot[gi] = (peak_reg == LEVEL_W'(gi + 1));
    end
  endgenerate

  assign o_level = level_reg;
  assign o_peak  = peak_reg;
  assign o_bar   = level_therm | peak_dot;

endmodule
